bigreg_sequencer: RTL and testbench
===================================

# bigreg_sequencer

Controller that services the processor-written multi-word registers in the mem_map: seeds, channel mux and sample discriminator config. It sits between the mem_map storage and the consumer logic. It watches the freshbit of each group's valid index and arbitrates round-robin between pending groups. For the granted group it reads the word addresses through a single read port, assembles them into one wide value, hands it off on a valid/ready interface, then clears the group's freshbits.

## Interface
- MEM_SIZE, 256, number of mem_map entries; address width is clog2(MEM_SIZE) = 8
- DATA_WIDTH, 16, bits per mem_map entry
- MAX_WORDS, 16, largest group size; output width is MAX_WORDS*DATA_WIDTH = 256
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- fresh_bits  in  MEM_SIZE  per-index freshbit (1 = PS wrote it, RTL has not consumed it)
- rd_en  out  1  read strobe to mem_map
- rd_addr  out  8  mem_map index being read
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
- clr_fresh  out  MEM_SIZE  one-cycle clear mask for freshbits
- big_data  out  256  assembled value; word k at [16k+15:16k]; unused upper bits 0
- big_id  out  2  group: 0 = seeds, 1 = chan mux, 2 = sdc
- big_valid  out  1  big_data/big_id valid
- big_ready  in  1  consumer accepts
- busy  out  1  high whenever state != IDLE

## Operation
- The group table is fixed:
  - seeds: base 1, 16 words, valid index 17
  - chan mux: base 32, 2 words, valid index 34
  - sdc: base 35, 16 words, valid index 51
- A group is pending when fresh_bits[valid index] = 1. Freshbits of the individual words are not checked; the words are read regardless.
- Arbitration is round-robin among pending groups.
  - Priority starts at the group after the last granted one.
  - After reset the order is 0, 1, 2.
  - The pointer updates only on grant.
- States:
  - IDLE: if any group is pending, latch the grant (group, base, N), set k = 0, go to READ.
  - READ: drive rd_en = 1 and rd_addr = base + k; increment k. After issuing k = N-1, go to DRAIN. Data for read k is captured into word slot k on the following cycle.
  - DRAIN: capture the last word; go to CLEAR.
  - CLEAR: clr_fresh has ones at indices base..valid index (N+1 bits) for exactly this cycle; go to PRESENT.
  - PRESENT: big_valid = 1 and big_id = group. big_data and big_id are held stable until big_valid && big_ready; on that handshake return to IDLE.
- big_data is zeroed on grant, so word slots unused by a 2-word group read 0.
- clr_fresh is 0 in every state except CLEAR.
- Reset values: rd_en 0, rd_addr 0, clr_fresh all 0, big_data 0, big_id 0, big_valid 0, busy 0, state IDLE, RR pointer = group 0 first.

## Timing
- Grant at cycle t, when IDLE sees a pending group.
- rd_en is high for cycles t+1 .. t+N.
- DRAIN at t+N+1, CLEAR at t+N+2.
- big_valid rises at t+N+3: 19 cycles for a 16-word group, 5 cycles for chan mux.
- With big_ready held high, IDLE is re-entered at t+N+4 and the next grant can occur that cycle.
- Boundary conditions:
  - Valid freshbit re-set by the PS after the CLEAR cycle: the group is serviced again in a later round. Data already latched is unaffected.
  - Valid freshbit cleared externally while the group is mid-read: the sequence still completes.
  - All three groups pending: service order follows the RR pointer; no group waits more than two full services.
  - big_ready high before big_valid: ignored.
  - big_ready low: PRESENT holds indefinitely and no other group is granted.
  - rst_n asserted mid-operation: all outputs immediately take their reset values and the latched group is discarded. Its freshbits remain set, so it is re-serviced after reset.

## Test plan
- Seed request only:
  - Stimulus: words 1..16 = 0x1000+k, fresh_bits[17] = 1, big_ready = 1.
  - Response: 16 consecutive rd_en with addr 1..16; clr_fresh = bits 1..17 at t+18; big_valid at t+19; big_id = 0; big_data word k = 0x1000+k.
- Chan mux request:
  - Stimulus: words 32/33 = 0xABCD/0x1234, fresh_bits[34] = 1.
  - Response: big_valid at t+5; big_id = 1; big_data = 0x1234_ABCD with upper 224 bits 0; clr_fresh = bits 32..34.
- All three groups pending from reset, big_ready = 1:
  - Response: grants in order 0, 1, 2. Re-raising 17 and 51 after group 0 completes gives order 1, 2, 0.
- Backpressure:
  - Stimulus: big_ready low for 10 cycles during PRESENT, with group 2 pending.
  - Response: big_data stable, no rd_en; group 2 granted in the cycle after the handshake.
- Reset mid-read:
  - Stimulus: rst_n low at read k = 5 of sdc.
  - Response: all outputs at reset values the same cycle; after release, sdc re-read from index 35 and completes normally.

Source files
------------

// File: rtl/bigreg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bigreg_sequencer                                                |
// | Purpose  : Services the processor-written multi-word mem_map registers     |
// |            (seeds, chan mux, sdc). Round-robin arbitration on each group's |
// |            valid freshbit, sequential word reads through one read port,    |
// |            wide-value hand-off on valid/ready, then freshbit clear.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bigreg_sequencer #(
  parameter int MEM_SIZE   = 256,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MEM_SIZE-1:0]               fresh_bits,
  output logic                              rd_en,
  output logic [$clog2(MEM_SIZE)-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0]             rd_data,
  output logic [MEM_SIZE-1:0]               clr_fresh,
  output logic [MAX_WORDS*DATA_WIDTH-1:0]   big_data,
  output logic [1:0]                        big_id,
  output logic                              big_valid,
  input  logic                              big_ready,
  output logic                              busy
);

  localparam int c_aw = $clog2(MEM_SIZE);
  localparam int c_kw = $clog2(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_CLEAR   = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  // Fixed group table: first word index of each group.
  function automatic logic [c_aw-1:0] f_base(input logic [1:0] g);
    case (g)
      2'd0:    f_base = c_aw'(1);
      2'd1:    f_base = c_aw'(32);
      default: f_base = c_aw'(35);
    endcase
  endfunction

  // Index of the last word of each group (word count minus one).
  function automatic logic [c_kw-1:0] f_last(input logic [1:0] g);
    case (g)
      2'd0:    f_last = c_kw'(15);
      2'd1:    f_last = c_kw'(1);
      default: f_last = c_kw'(15);
    endcase
  endfunction

  // Clear mask covers the data words plus the valid index right after them.
  function automatic logic [MEM_SIZE-1:0] f_mask(input logic [1:0] g);
    int lo;
    int hi;
    lo = int'(f_base(g));
    hi = lo + int'(f_last(g)) + 1;
    for (int i = 0; i < MEM_SIZE; i++) begin
      f_mask[i] = (i >= lo) && (i <= hi);
    end
  endfunction

  // Group index 'off' positions after g, wrapping over the three groups.
  function automatic logic [1:0] f_rot(input logic [1:0] g, input int off);
    int s;
    s = int'(g) + off;
    if (s >= 3) s = s - 3;
    f_rot = 2'(s);
  endfunction

  state_t              r_state;
  logic [1:0]          r_rr_ptr;
  logic [c_kw-1:0]     r_k;
  logic [c_kw-1:0]     r_last;
  logic                r_cap_en;
  logic [c_kw-1:0]     r_cap_slot;

  logic [3:0]          w_pend;
  logic                w_gnt_ok;
  logic [1:0]          w_gnt;
  logic                w_unused;

  // Only the three valid indices drive arbitration; the rest are folded away.
  assign w_pend   = {1'b0, fresh_bits[51], fresh_bits[34], fresh_bits[17]};
  assign w_unused = ^fresh_bits;

  // Round-robin pick: the pending group closest to the pointer wins.
  always_comb begin
    w_gnt_ok = 1'b0;
    w_gnt    = 2'd0;
    for (int off = 2; off >= 0; off--) begin
      if (w_pend[f_rot(r_rr_ptr, off)]) begin
        w_gnt_ok = 1'b1;
        w_gnt    = f_rot(r_rr_ptr, off);
      end
    end
  end

  // Sequencer: grant, read words, drain last word, clear freshbits, present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 2'd0;
      r_k        <= '0;
      r_last     <= '0;
      r_cap_en   <= 1'b0;
      r_cap_slot <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      clr_fresh  <= '0;
      big_data   <= '0;
      big_id     <= 2'd0;
      big_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe; remember which slot.
      r_cap_en   <= rd_en;
      r_cap_slot <= r_k;
      if (r_cap_en) begin
        big_data[int'(r_cap_slot)*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_ok) begin
            big_id   <= w_gnt;
            r_rr_ptr <= f_rot(w_gnt, 1);
            r_last   <= f_last(w_gnt);
            r_k      <= '0;
            rd_en    <= 1'b1;
            rd_addr  <= f_base(w_gnt);
            big_data <= '0;
            busy     <= 1'b1;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_k == r_last) begin
            rd_en   <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_k     <= r_k + c_kw'(1);
            rd_addr <= rd_addr + c_aw'(1);
          end
        end
        S_DRAIN: begin
          clr_fresh <= f_mask(big_id);
          r_state   <= S_CLEAR;
        end
        S_CLEAR: begin
          clr_fresh <= '0;
          big_valid <= 1'b1;
          r_state   <= S_PRESENT;
        end
        S_PRESENT: begin
          if (big_ready) begin
            big_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bigreg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_bigreg_sequencer                                             |
// | Purpose  : Directed bench for bigreg_sequencer with a mem_map/freshbit     |
// |            model and an expected-transaction queue.                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bigreg_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] fresh_bits = '0;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic [15:0]  rd_data = '0;
  logic [255:0] clr_fresh;
  logic [255:0] big_data;
  logic [1:0]   big_id;
  logic         big_valid;
  logic         big_ready;
  logic         busy;

  logic [255:0] set_req;
  logic [255:0] ext_clr;
  logic [15:0]  mem [256];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]   id;
    logic [255:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   order_q[$];

  bigreg_sequencer #(.MEM_SIZE(256), .DATA_WIDTH(16), .MAX_WORDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fresh_bits (fresh_bits),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .clr_fresh  (clr_fresh),
    .big_data   (big_data),
    .big_id     (big_id),
    .big_valid  (big_valid),
    .big_ready  (big_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // mem_map model: registered read port and freshbit storage.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    fresh_bits <= (fresh_bits & ~clr_fresh & ~ext_clr) | set_req;
  end

  function automatic logic [7:0] g_base(input logic [1:0] g);
    case (g)
      2'd0:    g_base = 8'd1;
      2'd1:    g_base = 8'd32;
      default: g_base = 8'd35;
    endcase
  endfunction

  function automatic int g_n(input logic [1:0] g);
    g_n = (g == 2'd1) ? 2 : 16;
  endfunction

  function automatic logic [255:0] g_mask(input logic [1:0] g);
    g_mask = '0;
    for (int i = 0; i <= g_n(g); i++) g_mask[int'(g_base(g)) + i] = 1'b1;
  endfunction

  function automatic logic [255:0] g_data(input logic [1:0] g);
    g_data = '0;
    for (int k = 0; k < g_n(g); k++) g_data[16*k +: 16] = mem[int'(g_base(g)) + k];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] g);
    exp_t e;
    e.id   = g;
    e.data = g_data(g);
    exp_q.push_back(e);
  endtask

  task automatic ps_set(input logic [255:0] m);
    @(negedge clk);
    set_req = m;
    @(negedge clk);
    set_req = '0;
  endtask

  // Monitor state
  logic         prev_busy;
  logic         prev_valid;
  logic [255:0] prev_data;
  logic [1:0]   prev_id;
  int           grant_t  = 0;
  int           rd_cnt   = 0;
  int           hs_count = 0;
  int           last_hs  = 0;

  task automatic wait_hs(input int n);
    int i;
    i = 0;
    while (hs_count < n && i < 300) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("handshake_wait", 256'(hs_count >= n), 256'(1));
  endtask

  // Protocol/timing monitor and scoreboard consumer.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
      rd_cnt     = 0;
    end else begin
      if (busy && !prev_busy) begin
        grant_t = cyc - 1;
        rd_cnt  = 0;
        order_q.push_back(int'(big_id));
      end
      if (rd_en) begin
        check("rd_addr", 256'(rd_addr), 256'(int'(g_base(big_id)) + rd_cnt));
        check("rd_cycle", 256'(cyc), 256'(grant_t + 1 + rd_cnt));
        rd_cnt++;
      end
      if (clr_fresh != '0) begin
        check("clr_mask", clr_fresh, g_mask(big_id));
        check("clr_cycle", 256'(cyc), 256'(grant_t + g_n(big_id) + 2));
        check("rd_count", 256'(rd_cnt), 256'(g_n(big_id)));
      end
      if (big_valid && !prev_valid) begin
        check("valid_cycle", 256'(cyc), 256'(grant_t + g_n(big_id) + 3));
      end
      if (big_valid && prev_valid) begin
        check("hold_data", big_data, prev_data);
        check("hold_id", 256'(big_id), 256'(prev_id));
      end
      if (big_valid && big_ready) begin
        check("sb_pending", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_id", 256'(big_id), 256'(e.id));
          check("out_data", big_data, e.data);
        end
        hs_count++;
        last_hs = cyc;
      end
      prev_busy  = busy;
      prev_valid = big_valid;
      prev_data  = big_data;
      prev_id    = big_id;
    end
  end

  initial begin
    int h;
    int i;
    rst_n     = 1'b0;
    big_ready = 1'b0;
    set_req   = '0;
    ext_clr   = '0;
    for (int a = 0; a < 256; a++) mem[a] = 16'(a * 3 + 7);
    for (int k = 0; k < 16; k++) begin
      mem[1 + k]  = 16'(16'h1000 + k);
      mem[35 + k] = 16'(16'h5D00 + k);
    end
    mem[32] = 16'hABCD;
    mem[33] = 16'h1234;

    // Reset values
    #2;
    check("rst_rd_en", 256'(rd_en), 256'(0));
    check("rst_rd_addr", 256'(rd_addr), 256'(0));
    check("rst_clr", clr_fresh, '0);
    check("rst_big_data", big_data, '0);
    check("rst_ctl", 256'({big_id, big_valid, busy}), 256'(0));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    big_ready = 1'b1;

    // Seed request alone; ready already high before valid.
    push_exp(2'd0);
    ps_set(256'(1) << 17);
    wait_hs(1);
    check("seed_fresh_cleared", 256'(fresh_bits[17:1]), 256'(0));

    // Chan mux request with its word freshbits also set.
    push_exp(2'd1);
    ps_set((256'(1) << 32) | (256'(1) << 33) | (256'(1) << 34));
    wait_hs(2);
    check("chan_fresh_cleared", 256'(fresh_bits[34:32]), 256'(0));
    check("chan_literal", g_data(2'd1), 256'h1234_ABCD);

    // Backpressure: hold PRESENT while sdc becomes pending.
    @(negedge clk);
    big_ready = 1'b0;
    push_exp(2'd1);
    push_exp(2'd2);
    ps_set(256'(1) << 34);
    i = 0;
    while (!big_valid && i < 50) begin
      @(negedge clk);
      #2;
      i++;
    end
    check("bp_valid_seen", 256'(big_valid), 256'(1));
    ps_set(256'(1) << 51);
    repeat (10) begin
      @(negedge clk);
      #2;
      check("bp_hold", 256'({rd_en, big_valid, big_id}), 256'({1'b0, 1'b1, 2'd1}));
    end
    @(negedge clk);
    big_ready = 1'b1;
    wait_hs(3);
    h = last_hs;
    wait_hs(4);
    check("bp_next_grant", 256'(grant_t), 256'(h + 1));
    check("bp_next_group", 256'(order_q[order_q.size()-1]), 256'(2));

    // All three pending from reset, then re-raise seeds and sdc.
    @(negedge clk);
    rst_n   = 1'b0;
    set_req = (256'(1) << 17) | (256'(1) << 34) | (256'(1) << 51);
    @(negedge clk);
    set_req = '0;
    @(negedge clk);
    order_q.delete();
    rst_n = 1'b1;
    push_exp(2'd0);
    push_exp(2'd1);
    push_exp(2'd2);
    push_exp(2'd0);
    wait_hs(5);
    ps_set((256'(1) << 17) | (256'(1) << 51));
    wait_hs(8);
    check("rr_count", 256'(order_q.size()), 256'(4));
    check("rr_order", 256'({order_q[0][1:0], order_q[1][1:0], order_q[2][1:0], order_q[3][1:0]}),
          256'({2'd0, 2'd1, 2'd2, 2'd0}));

    // Valid freshbit cleared externally while the group is being read.
    push_exp(2'd1);
    ps_set(256'(1) << 34);
    i = 0;
    while (i < 50) begin
      @(negedge clk);
      if (rd_en) break;
      i++;
    end
    ext_clr = 256'(1) << 34;
    @(negedge clk);
    ext_clr = '0;
    wait_hs(9);
    check("extclr_fresh", 256'(fresh_bits[34]), 256'(0));

    // Reset during read k=5 of sdc, then re-service after release.
    ps_set(256'(1) << 51);
    i = 0;
    while (i < 50) begin
      @(negedge clk);
      if (rd_en && rd_addr == 8'd40) break;
      i++;
    end
    check("midrst_reached", 256'(rd_en && rd_addr == 8'd40), 256'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 256'({rd_en, rd_addr, big_id, big_valid, busy}), 256'(0));
    check("midrst_clr", clr_fresh, '0);
    check("midrst_data", big_data, '0);
    check("midrst_fresh_kept", 256'(fresh_bits[51]), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(2'd2);
    wait_hs(10);
    check("midrst_regrant", 256'(order_q[order_q.size()-1]), 256'(2));

    repeat (3) @(negedge clk);
    check("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
